// File: rtl/delay_pkg.sv
// Shared types and default sizing for the multi-channel delay timer.
package delay_pkg;

  localparam int unsigned CBITS     = 15;
  localparam int unsigned DEFAULT_N = 17500;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/multi_delay_timer_if.sv
// Configuration write channel: valid/ready handshake carrying channel, period and mode.
interface multi_delay_timer_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CBITS = 15
) ();
  import delay_pkg::*;

  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CHW-1:0]   cfg_ch;
  logic [CBITS-1:0] cfg_period;
  mode_e            cfg_mode;

  modport master (
    output cfg_valid, cfg_ch, cfg_period, cfg_mode,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_period, cfg_mode,
    output cfg_ready
  );

endinterface

// File: rtl/delay_channel.sv
// One timer channel: counter, IDLE/RUN state machine, period/mode storage and sticky invariant flag.
module delay_channel #(
  parameter int unsigned CBITS     = 15,
  parameter int unsigned DEFAULT_N = 17500
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we_i,
  input  logic [CBITS-1:0]   cfg_period_i,
  input  delay_pkg::mode_e   cfg_mode_i,
  input  logic               start_i,
  input  logic               stop_i,
  output logic               sig_o,
  output logic               busy_o,
  output logic               err_o,
  output logic [CBITS-1:0]   period_o
);
  import delay_pkg::*;

  state_e           state_q;
  mode_e            mode_q;
  logic [CBITS-1:0] cnt_q;
  logic [CBITS-1:0] period_q;
  logic             sig_q;
  logic             err_q;

  // Priority in RUN: stop, then retrigger, then expiry, then count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_PERIODIC;
      cnt_q    <= '0;
      period_q <= CBITS'(DEFAULT_N);
      sig_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sig_q <= 1'b0;
      if (cfg_we_i) begin
        period_q <= cfg_period_i;
        mode_q   <= cfg_mode_i;
      end
      if ((state_q == ST_RUN) && (cnt_q > period_q)) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_i && !stop_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
          end
        end
        ST_RUN: begin
          if (stop_i) begin
            state_q <= ST_IDLE;
          end else if (start_i) begin
            cnt_q <= '0;
          end else if (cnt_q == period_q) begin
            sig_q <= 1'b1;
            cnt_q <= '0;
            if (mode_q == MODE_ONESHOT) begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CBITS'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sig_o    = sig_q;
  assign busy_o   = (state_q == ST_RUN);
  assign err_o    = err_q;
  assign period_o = period_q;

endmodule

// File: rtl/multi_delay_timer.sv
// Multi-channel programmable delay timer: config decode, ready mux and per-channel instances.
module multi_delay_timer #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned CBITS     = 15,
  parameter int unsigned DEFAULT_N = 17500
) (
  input  logic                 clk,
  input  logic                 rst,
  multi_delay_timer_if.slave   cfg,
  input  logic [NCH-1:0]       start_i,
  input  logic [NCH-1:0]       stop_i,
  output logic [NCH-1:0]       sig_o,
  output logic [NCH-1:0]       busy_o,
  output logic [NCH-1:0]       err_o
);
  import delay_pkg::*;

  localparam int unsigned GW = CBITS + 1;

  logic [CBITS-1:0] period_w [NCH];

  // Ready reflects the registered busy of the addressed channel; unmapped channels always accept.
  always_comb begin
    cfg.cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (32'(cfg.cfg_ch) == 32'(i)) begin
        cfg.cfg_ready = !busy_o[i];
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic          cfg_we;
    logic [GW-1:0] gap_q;
    logic          armed_q;
    logic          sig_prev_q;

    assign cfg_we = cfg.cfg_valid && cfg.cfg_ready && (32'(cfg.cfg_ch) == 32'(i));

    delay_channel #(
      .CBITS     (CBITS),
      .DEFAULT_N (DEFAULT_N)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .cfg_we_i     (cfg_we),
      .cfg_period_i (cfg.cfg_period),
      .cfg_mode_i   (cfg.cfg_mode),
      .start_i      (start_i[i]),
      .stop_i       (stop_i[i]),
      .sig_o        (sig_o[i]),
      .busy_o       (busy_o[i]),
      .err_o        (err_o[i]),
      .period_o     (period_w[i])
    );

    // Invariant checks: err stays low, pulses are single-cycle unless P=0, undisturbed periodic spacing is P+1.
    always_ff @(posedge clk) begin
      if (rst) begin
        gap_q      <= '0;
        armed_q    <= 1'b0;
        sig_prev_q <= 1'b0;
      end else begin
        assert (!err_o[i]);
        assert (!(sig_o[i] && sig_prev_q) || (period_w[i] == '0));
        if (sig_o[i]) begin
          assert (!armed_q || (gap_q == {1'b0, period_w[i]}));
        end
        sig_prev_q <= sig_o[i];
        if (start_i[i] || stop_i[i]) begin
          armed_q <= 1'b0;
        end else if (sig_o[i]) begin
          armed_q <= busy_o[i];
        end
        gap_q <= sig_o[i] ? '0 : gap_q + GW'(1);
      end
    end
  end

endmodule

// File: tb/tb_multi_delay_timer.sv
// Directed self-checking bench for multi_delay_timer.
module tb_multi_delay_timer;
  import delay_pkg::*;

  localparam int unsigned NCH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] start;
  logic [NCH-1:0] stop;
  logic [NCH-1:0] sig;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] err;
  logic [NCH-1:0] seen;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_delay_timer_if #(.NCH(NCH), .CBITS(CBITS)) cfg_if ();

  multi_delay_timer #(
    .NCH       (NCH),
    .CBITS     (CBITS),
    .DEFAULT_N (17500)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg     (cfg_if),
    .start_i (start),
    .stop_i  (stop),
    .sig_o   (sig),
    .busy_o  (busy),
    .err_o   (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_set(input int ch, input int p, input mode_e m);
    cfg_if.cfg_ch     = 2'(ch);
    cfg_if.cfg_period = CBITS'(p);
    cfg_if.cfg_mode   = m;
    cfg_if.cfg_valid  = 1'b1;
  endtask

  initial begin
    rst               = 1'b1;
    start             = '0;
    stop              = '0;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_ch     = '0;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_mode   = MODE_PERIODIC;
    step(3);
    rst = 1'b0;
    chk("rst_sig", 32'(sig), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ready", 32'(cfg_if.cfg_ready), 1);

    // ch1: P=3 one-shot written in the same cycle as its start
    cfg_set(1, 3, MODE_ONESHOT);
    start = 4'b0010;
    chk("ch1_ready", 32'(cfg_if.cfg_ready), 1);
    step(1);
    cfg_if.cfg_valid = 1'b0;
    start = '0;
    chk("ch1_busy_start", 32'(busy), 32'h2);
    chk("ch1_sig_start", 32'(sig), 0);
    step(3);
    chk("ch1_pre_pulse", 32'(sig), 0);
    step(1);
    chk("ch1_pulse", 32'(sig), 32'h2);
    chk("ch1_busy_fall", 32'(busy), 0);
    step(1);
    chk("ch1_pulse_end", 32'(sig), 0);
    step(6);
    chk("ch1_no_repeat", 32'(sig), 0);
    chk("ch1_idle", 32'(busy), 0);

    // ch2: P=0 periodic pulses every cycle until stopped
    cfg_set(2, 0, MODE_PERIODIC);
    step(1);
    cfg_if.cfg_valid = 1'b0;
    start = 4'b0100;
    step(1);
    start = '0;
    chk("ch2_busy", 32'(busy), 32'h4);
    chk("ch2_sig0", 32'(sig), 0);
    step(1);
    chk("ch2_sig1", 32'(sig), 32'h4);
    step(1);
    chk("ch2_sig2", 32'(sig), 32'h4);
    stop = 4'b0100;
    step(1);
    stop = '0;
    chk("ch2_stop_sig", 32'(sig), 0);
    chk("ch2_stop_busy", 32'(busy), 0);

    // ch3: P=5 periodic, stalled config write, retrigger at cnt=4
    cfg_set(3, 5, MODE_PERIODIC);
    step(1);
    cfg_if.cfg_valid = 1'b0;
    start = 4'b1000;
    step(1);
    start = '0;
    cfg_set(3, 9, MODE_PERIODIC);
    chk("ch3_stall0", 32'(cfg_if.cfg_ready), 0);
    step(4);
    chk("ch3_stall1", 32'(cfg_if.cfg_ready), 0);
    chk("ch3_cnt4_sig", 32'(sig), 0);
    start = 4'b1000;
    step(1);
    start = '0;
    step(1);
    chk("ch3_old_expiry_gone", 32'(sig), 0);
    step(4);
    chk("ch3_retrig_pre", 32'(sig), 0);
    step(1);
    chk("ch3_retrig_pulse", 32'(sig), 32'h8);
    chk("ch3_stall2", 32'(cfg_if.cfg_ready), 0);
    stop = 4'b1000;
    step(1);
    stop = '0;
    chk("ch3_stop_busy", 32'(busy), 0);
    chk("ch3_ready_after_stop", 32'(cfg_if.cfg_ready), 1);
    step(1);
    cfg_if.cfg_valid = 1'b0;
    start = 4'b1000;
    step(1);
    start = '0;
    step(9);
    chk("ch3_p9_pre", 32'(sig), 0);
    step(1);
    chk("ch3_p9_pulse", 32'(sig), 32'h8);
    stop = 4'b1000;
    step(1);
    stop = '0;
    chk("ch3_final_idle", 32'(busy), 0);

    // ch0: start and stop together leave the channel idle
    start = 4'b0001;
    stop  = 4'b0001;
    step(1);
    start = '0;
    stop  = '0;
    chk("ch0_ss_busy", 32'(busy), 0);
    step(3);
    chk("ch0_ss_sig", 32'(sig), 0);
    chk("ch0_ss_busy_late", 32'(busy), 0);

    // ch0: reset at cnt=100 of P=200 aborts everything
    cfg_set(0, 200, MODE_PERIODIC);
    step(1);
    cfg_if.cfg_valid = 1'b0;
    start = 4'b0001;
    step(1);
    start = '0;
    step(100);
    chk("ch0_run_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    step(1);
    chk("rst_mid_sig", 32'(sig), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_err", 32'(err), 0);
    rst  = 1'b0;
    seen = '0;
    for (int i = 0; i < 250; i++) begin
      step(1);
      seen = seen | sig | busy;
    end
    chk("rst_mid_quiet", 32'(seen), 0);

    // ch0: default period restored by reset, periodic pulses at 17501/35002/52503
    start = 4'b0001;
    step(1);
    start = '0;
    for (int p = 0; p < 3; p++) begin
      step(17500);
      chk("dflt_pre", 32'(sig), 0);
      step(1);
      chk("dflt_pulse", 32'(sig), 32'h1);
      chk("dflt_busy", 32'(busy), 32'h1);
    end
    step(1);
    chk("dflt_pulse_end", 32'(sig), 0);
    chk("final_err", 32'(err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
